// File: rtl/agc_ctr_pkg.sv
// Shared types and defaults for the AGC counter-increment cycle-steal scheduler.
package agc_ctr_pkg;

  localparam int unsigned CTR_NCTR_DEF      = 20;
  localparam logic [11:0] CTR_BASE_ADDR_DEF = 12'o0024;
  localparam int unsigned CTR_IDX_W         = $clog2(CTR_NCTR_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    STEAL = 1'b1
  } steal_state_e;

endpackage

// File: rtl/ctr_prio_enc.sv
// Lowest-index-first priority encoder: index 0 wins over every other request.
module ctr_prio_enc
  import agc_ctr_pkg::*;
#(
  parameter int unsigned N  = CTR_NCTR_DEF,
  parameter int unsigned IW = CTR_IDX_W
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    // NOTE: outputs get a default before the loop so no path leaves them unassigned (no latch).
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/ctr_steal_sched.sv
// Counter-increment cycle-steal scheduler: latches plus/minus pulse edges per
// counter cell and steals whole memory cycles, one at a time, in fixed priority.
module ctr_steal_sched
  import agc_ctr_pkg::*;
#(
  parameter int unsigned NCTR      = CTR_NCTR_DEF,
  parameter logic [11:0] BASE_ADDR = CTR_BASE_ADDR_DEF,
  parameter int unsigned LOSTW     = 8
) (
  input  logic             CLOCK,
  input  logic             SIM_RST_n,
  input  logic [NCTR-1:0]  PINC_REQ,
  input  logic [NCTR-1:0]  MINC_REQ,
  input  logic             CYCLE_END,
  input  logic             INHINC,
  output logic             INKL,
  output logic [11:0]      CTR_ADDR,
  output logic             PINC,
  output logic             MINC,
  output logic             CTR_DONE,
  output logic             PENDING,
  output logic [LOSTW-1:0] LOST_CNT
);

  localparam int unsigned IW = (NCTR > 1) ? $clog2(NCTR) : 1;
  localparam logic [NCTR-1:0] BIT0 = {{(NCTR-1){1'b0}}, 1'b1};

  logic [NCTR-1:0]  req_p_q, req_m_q;
  logic [NCTR-1:0]  pend_p_q, pend_p_d, pend_m_q, pend_m_d;
  steal_state_e     state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             plus_q, plus_d;
  logic             done_q, done_d;
  logic [LOSTW-1:0] lost_q, lost_d;

  logic [NCTR-1:0]  rise_p, rise_m, clr_p, clr_m, cand, keep, cancel, lost_p, lost_m;
  logic             retire, win_valid, win_plus;
  logic [IW-1:0]    win_idx;

  assign rise_p = PINC_REQ & ~req_p_q;
  assign rise_m = MINC_REQ & ~req_m_q;

  // The granted bit is retired on the CYCLE_END that closes its stolen cycle.
  assign retire = (state_q == STEAL) && CYCLE_END;
  assign clr_p  = (retire &&  plus_q) ? (BIT0 << idx_q) : '0;
  assign clr_m  = (retire && !plus_q) ? (BIT0 << idx_q) : '0;

  // Winner candidates exclude the bit being retired so back-to-back grants move on.
  assign cand     = (pend_p_q & ~clr_p) | (pend_m_q & ~clr_m);
  assign win_plus = pend_p_q[win_idx] & ~clr_p[win_idx];

  ctr_prio_enc #(.N(NCTR), .IW(IW)) u_prio (
    .req_i   (cand),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  // Grant/retire sequencing: direction and address are frozen at grant time.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    plus_d  = plus_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (CYCLE_END && win_valid && !INHINC) begin
          state_d = STEAL;
          idx_d   = win_idx;
          plus_d  = win_plus;
        end
      end
      STEAL: begin
        if (CYCLE_END) begin
          done_d = 1'b1;
          if (win_valid && !INHINC) begin
            idx_d  = win_idx;
            plus_d = win_plus;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending-bit update: set beats clear, opposite directions cancel except on
  // the counter that holds the grant after this clock, repeat edges are lost.
  always_comb begin
    pend_p_d = (pend_p_q & ~clr_p) | rise_p;
    pend_m_d = (pend_m_q & ~clr_m) | rise_m;
    keep     = (state_d == STEAL) ? (BIT0 << idx_d) : '0;
    cancel   = pend_p_d & pend_m_d & ~keep;
    lost_p   = rise_p & pend_p_q & ~clr_p & ~cancel;
    lost_m   = rise_m & pend_m_q & ~clr_m & ~cancel;
    pend_p_d = pend_p_d & ~cancel;
    pend_m_d = pend_m_d & ~cancel;
    lost_d   = lost_q;
    for (int i = 0; i < int'(NCTR); i++) begin
      if (lost_p[i] && lost_d != '1) lost_d = lost_d + LOSTW'(1);
      if (lost_m[i] && lost_d != '1) lost_d = lost_d + LOSTW'(1);
    end
  end

  // State, edge-detect and pending registers.
  always_ff @(posedge CLOCK or negedge SIM_RST_n) begin
    // NOTE: every register, pending vectors included, is reset so a reset mid-steal leaves no trace.
    if (!SIM_RST_n) begin
      req_p_q  <= '0;
      req_m_q  <= '0;
      pend_p_q <= '0;
      pend_m_q <= '0;
      state_q  <= IDLE;
      idx_q    <= '0;
      plus_q   <= 1'b0;
      done_q   <= 1'b0;
      lost_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      req_p_q  <= PINC_REQ;
      req_m_q  <= MINC_REQ;
      pend_p_q <= pend_p_d;
      pend_m_q <= pend_m_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      plus_q   <= plus_d;
      done_q   <= done_d;
      lost_q   <= lost_d;
    end
  end

  assign INKL     = (state_q == STEAL);
  assign CTR_ADDR = INKL ? (BASE_ADDR + 12'(idx_q)) : 12'd0;
  assign PINC     = INKL &  plus_q;
  assign MINC     = INKL & ~plus_q;
  assign CTR_DONE = done_q;
  assign PENDING  = |(pend_p_q | pend_m_q);
  assign LOST_CNT = lost_q;

endmodule

// File: doc/ctr_steal_sched.md
Name: ctr_steal_sched

Overview:
- Counter-increment cycle-steal scheduler for the AGC counter cells (TIME1..CDU/PIPA region).
- Latches asynchronous plus/minus pulse requests per counter and steals whole memory cycles from the sequencer, one at a time, in fixed priority.
- For each stolen cycle it drives INKL, the counter address, and the PINC/MINC selection into the existing control-pulse/adder path.
- Sits between peripheral pulse sources (PIPPLS, CDU, timer) and the main timing/sequence generator.

Parameters:
- NCTR, 20, number of counter cells serviced; index 0 has highest priority.
- BASE_ADDR, 12'o0024, erasable address of counter index 0; counter i is at BASE_ADDR+i.
- LOSTW, 8, width of the saturating lost-pulse counter.

Ports:
- CLOCK  in  1  system clock.
- SIM_RST_n  in  1  reset, asynchronous assert, active-low.
- PINC_REQ  in  NCTR  plus-pulse request per counter; level, rising edge counts.
- MINC_REQ  in  NCTR  minus-pulse request per counter; level, rising edge counts.
- CYCLE_END  in  1  one-CLOCK strobe marking the memory-cycle boundary (T12).
- INHINC  in  1  inhibit new steals (instruction in a non-interruptible phase); a steal already granted still completes.
- INKL  out  1  high for the whole stolen memory cycle.
- CTR_ADDR  out  12  address of the counter being serviced; 0 when INKL=0.
- PINC  out  1  stolen cycle is +1.
- MINC  out  1  stolen cycle is -1.
- CTR_DONE  out  1  one-CLOCK pulse when a stolen cycle retires.
- PENDING  out  1  any request latched.
- LOST_CNT  out  LOSTW  saturating count of dropped pulses.

Behaviour:
- Reset: all pending bits 0, edge-detect registers 0, state IDLE; INKL=0, CTR_ADDR=0, PINC=0, MINC=0, CTR_DONE=0, PENDING=0, LOST_CNT=0. Reset mid-steal aborts the cycle with no CTR_DONE.
- Edge detect: register inputs once; a rising edge sets pend_p[i] or pend_m[i] on the next CLOCK.
- Edge on an already-set pending bit: bit stays set, LOST_CNT increments, saturating at all-ones.
- Cancellation: if pend_p[i] and pend_m[i] would both be set after a CLOCK, both clear; no steal; no LOST_CNT change.
- Winner: lowest i with (pend_p[i] | pend_m[i]), computed combinationally. PENDING is the OR of all pending bits.
- FSM IDLE:
  - On CYCLE_END & PENDING & !INHINC, latch winner index and direction, go STEAL.
  - Outputs assert on the next CLOCK: INKL=1, CTR_ADDR=BASE_ADDR+idx, PINC or MINC (one-hot).
- FSM STEAL:
  - Outputs are held stable for the full memory cycle.
  - On CYCLE_END, clear the granted pending bit and pulse CTR_DONE for one CLOCK.
  - Then, if other pending remains and !INHINC, latch the next winner in the same CLOCK (back-to-back, INKL stays 1). Otherwise drop INKL/PINC/MINC and set CTR_ADDR=0, go IDLE.
- Simultaneous clear and new edge on the granted bit in the same CLOCK: set wins, the bit remains pending, not counted as lost.
- Opposite-direction edge on the granted counter during STEAL: latches normally; cancellation applies only among non-granted bits. The granted direction is fixed at grant.
- Requests changing during STEAL never alter CTR_ADDR or PINC/MINC of the current steal.
- INHINC rising during STEAL does not abort the steal; it blocks only the next grant.
- Latency: request edge to INKL is at most 1 cycle edge + 1 CYCLE_END + 1 CLOCK when idle and highest priority.

Decomposition:
- Package agc_ctr_pkg: FSM state enum (IDLE, STEAL), BASE_ADDR default, index width constant $clog2(NCTR).
- Sub-module ctr_prio_enc: parameterised NCTR-input lowest-index-first priority encoder (valid + index). Everything else stays in ctr_steal_sched.

Test Plan:
- Reset with PINC_REQ[3] high -> all outputs 0, LOST_CNT=0. After release, held level causes exactly one pend_p[3] at the first rising edge only.
- Pulse PINC_REQ[5] in IDLE, then CYCLE_END -> next CLOCK INKL=1, CTR_ADDR=12'o0031, PINC=1. Next CYCLE_END -> CTR_DONE pulse, INKL=0, PENDING=0.
- Pulse MINC_REQ[7] and PINC_REQ[2] together -> first steal addr 12'o0026 PINC. Back-to-back second steal addr 12'o0033 MINC with INKL never dropping; two CTR_DONE pulses.
- Pulse PINC_REQ[4] then MINC_REQ[4] before any CYCLE_END -> both bits cancel, PENDING=0, no INKL at CYCLE_END, LOST_CNT=0.
- Three PINC_REQ[0] edges with INHINC=1 -> PENDING=1, no INKL, LOST_CNT=2. Drop INHINC -> single steal at 12'o0024. Force 300 edges -> LOST_CNT saturates at 255.
- Assert SIM_RST_n=0 mid-STEAL -> INKL/PINC/CTR_ADDR go 0 immediately (asynchronous), no CTR_DONE, pending cleared.
